// File: rtl/sram_bist_march_ctrl_pkg.sv
// Shared types and constants for the March C- SRAM BIST controller.
// The checkerboard background is only used when SRAM_BIST_CKBD_EN is defined.
package sram_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    E0 = 3'd0,
    E1 = 3'd1,
    E2 = 3'd2,
    E3 = 3'd3,
    E4 = 3'd4,
    E5 = 3'd5
  } elem_t;

  // Polarity bits select D1 (inverted background) when set.
  typedef struct packed {
    logic down;
    logic rd_inv;
    logic wr_inv;
    logic has_rd;
    logic has_wr;
  } elem_cfg_t;

  localparam logic [7:0] CKBD_PATTERN = 8'h55;

  function automatic elem_cfg_t elem_cfg(input elem_t e);
    elem_cfg_t c;
    c = '0;
    case (e)
      E0:      c = '{down: 1'b0, rd_inv: 1'b0, wr_inv: 1'b0, has_rd: 1'b0, has_wr: 1'b1};
      E1:      c = '{down: 1'b0, rd_inv: 1'b0, wr_inv: 1'b1, has_rd: 1'b1, has_wr: 1'b1};
      E2:      c = '{down: 1'b0, rd_inv: 1'b1, wr_inv: 1'b0, has_rd: 1'b1, has_wr: 1'b1};
      E3:      c = '{down: 1'b1, rd_inv: 1'b0, wr_inv: 1'b1, has_rd: 1'b1, has_wr: 1'b1};
      E4:      c = '{down: 1'b1, rd_inv: 1'b1, wr_inv: 1'b0, has_rd: 1'b1, has_wr: 1'b1};
      E5:      c = '{down: 1'b0, rd_inv: 1'b0, wr_inv: 1'b0, has_rd: 1'b1, has_wr: 1'b0};
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/sram_bist_march_ctrl_if.sv
// BIST-side connection between the March C- controller and an SRAM macro.
interface sram_bist_march_ctrl_if #(
  parameter int P_ADDR_WIDTH = 8,
  parameter int P_DATA_WIDTH = 8
) ();
  logic                    A_BIST_EN;
  logic                    A_BIST_MEN;
  logic                    A_BIST_WEN;
  logic                    A_BIST_REN;
  logic [P_ADDR_WIDTH-1:0] A_BIST_ADDR;
  logic [P_DATA_WIDTH-1:0] A_BIST_DIN;
  logic [P_DATA_WIDTH-1:0] A_BIST_BM;
  logic [P_DATA_WIDTH-1:0] A_DOUT;

  modport master (
    output A_BIST_EN, A_BIST_MEN, A_BIST_WEN, A_BIST_REN,
    output A_BIST_ADDR, A_BIST_DIN, A_BIST_BM,
    input  A_DOUT
  );

  modport slave (
    input  A_BIST_EN, A_BIST_MEN, A_BIST_WEN, A_BIST_REN,
    input  A_BIST_ADDR, A_BIST_DIN, A_BIST_BM,
    output A_DOUT
  );
endinterface

// File: rtl/sram_bist_march_ctrl_cmp.sv
// Read-compare pipeline: tracks each read through the macro's one-cycle read
// latency, compares A_DOUT against the expected data and keeps the first miscompare.
module sram_bist_cmp #(
  parameter int P_ADDR_WIDTH = 8,
  parameter int P_DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    rd_issue,
  input  logic [P_DATA_WIDTH-1:0] rd_exp,
  input  logic [P_ADDR_WIDTH-1:0] rd_addr,
  input  logic [P_DATA_WIDTH-1:0] dout,
  output logic                    fail,
  output logic [P_ADDR_WIDTH-1:0] fail_addr,
  output logic [P_DATA_WIDTH-1:0] fail_data
);

  logic                    pres_vld, samp_vld;
  logic [P_DATA_WIDTH-1:0] pres_exp, samp_exp;
  logic [P_ADDR_WIDTH-1:0] pres_addr, samp_addr;

  // Stage 1 loads with the presented read, stage 2 at the macro's sampling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pres_vld  <= 1'b0;
      pres_exp  <= '0;
      pres_addr <= '0;
      samp_vld  <= 1'b0;
      samp_exp  <= '0;
      samp_addr <= '0;
    end else begin
      pres_vld  <= rd_issue;
      pres_exp  <= rd_exp;
      pres_addr <= rd_addr;
      samp_vld  <= pres_vld;
      samp_exp  <= pres_exp;
      samp_addr <= pres_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_data <= '0;
    end else if (clear) begin
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_data <= '0;
    end else if (samp_vld && (dout != samp_exp) && !fail) begin
      fail      <= 1'b1;
      fail_addr <= samp_addr;
      fail_data <= dout;
    end
  end

endmodule

// File: rtl/sram_bist_march_ctrl.sv
// March C- BIST sequencer for a single-port SRAM BIST port.
// Define SRAM_BIST_CKBD_EN to append a second pass on a 0x55 checkerboard background.
module sram_bist_march_ctrl
  import sram_bist_pkg::*;
#(
  parameter int P_ADDR_WIDTH = 8,
  parameter int P_DATA_WIDTH = 8
) (
  input  logic                    A_BIST_CLK,
  input  logic                    A_BIST_RST_N,
  input  logic                    START,
  output logic                    BUSY,
  output logic                    DONE,
  output logic                    FAIL,
  output logic [P_ADDR_WIDTH-1:0] FAIL_ADDR,
  output logic [P_DATA_WIDTH-1:0] FAIL_DATA,
  sram_bist_march_ctrl_if.master  bist
);

  localparam logic [P_ADDR_WIDTH-1:0] ADDR_MAX = '1;
  localparam logic [P_ADDR_WIDTH-1:0] ADDR_ONE = P_ADDR_WIDTH'(1);

  state_t                  state_q, state_d;
  elem_t                   elem_q, elem_d;
  logic [P_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                    phase_q, phase_d;
  logic                    start_run, last_op, op_rd, run_d;
  logic [P_DATA_WIDTH-1:0] bg_d, exp_d;

  logic                    busy_q, done_q, men_q, wen_q, ren_q;
  logic [P_ADDR_WIDTH-1:0] addr_out_q;
  logic [P_DATA_WIDTH-1:0] din_q, bm_q;

`ifdef SRAM_BIST_CKBD_EN
  logic                    pass_q, pass_d;
  logic [P_DATA_WIDTH-1:0] ckbd;

  always_comb begin
    ckbd = '0;
    for (int i = 0; i < P_DATA_WIDTH; i++) ckbd[i] = CKBD_PATTERN[i % 8];
  end
`endif

  // Sequencer state describes the op that will be presented after the next edge;
  // the macro-facing outputs are decoded from it and registered.
  always_comb begin
    state_d   = state_q;
    elem_d    = elem_q;
    addr_d    = addr_q;
    phase_d   = phase_q;
    start_run = 1'b0;
`ifdef SRAM_BIST_CKBD_EN
    pass_d    = pass_q;
`endif
    last_op = !(elem_cfg(elem_q).has_rd && elem_cfg(elem_q).has_wr) || phase_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (START) begin
          state_d   = ST_RUN;
          elem_d    = E0;
          addr_d    = '0;
          phase_d   = 1'b0;
          start_run = 1'b1;
`ifdef SRAM_BIST_CKBD_EN
          pass_d    = 1'b0;
`endif
        end
      end
      ST_RUN: begin
        if (!last_op) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (addr_q == (elem_cfg(elem_q).down ? '0 : ADDR_MAX)) begin
            if (elem_q == E5) begin
`ifdef SRAM_BIST_CKBD_EN
              if (!pass_q) begin
                pass_d = 1'b1;
                elem_d = E0;
                addr_d = '0;
              end else begin
                state_d = ST_DRAIN;
              end
`else
              state_d = ST_DRAIN;
`endif
            end else begin
              elem_d = elem_t'(elem_q + 3'd1);
              addr_d = elem_cfg(elem_d).down ? ADDR_MAX : '0;
            end
          end else begin
            addr_d = elem_cfg(elem_q).down ? (addr_q - ADDR_ONE) : (addr_q + ADDR_ONE);
          end
        end
      end
      ST_DRAIN: state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase

`ifdef SRAM_BIST_CKBD_EN
    bg_d  = pass_d ? ckbd : '0;
`else
    bg_d  = '0;
`endif
    run_d = (state_d == ST_RUN);
    op_rd = run_d && elem_cfg(elem_d).has_rd && (!elem_cfg(elem_d).has_wr || !phase_d);
    exp_d = elem_cfg(elem_d).rd_inv ? ~bg_d : bg_d;
  end

  always_ff @(posedge A_BIST_CLK or negedge A_BIST_RST_N) begin
    if (!A_BIST_RST_N) begin
      state_q    <= ST_IDLE;
      elem_q     <= E0;
      addr_q     <= '0;
      phase_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      men_q      <= 1'b0;
      wen_q      <= 1'b0;
      ren_q      <= 1'b0;
      addr_out_q <= '0;
      din_q      <= '0;
      bm_q       <= '0;
`ifdef SRAM_BIST_CKBD_EN
      pass_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      elem_q     <= elem_d;
      addr_q     <= addr_d;
      phase_q    <= phase_d;
      busy_q     <= (state_d == ST_RUN) || (state_d == ST_DRAIN);
      done_q     <= (state_d == ST_DONE);
      men_q      <= run_d;
      wen_q      <= run_d && !op_rd;
      ren_q      <= op_rd;
      addr_out_q <= run_d ? addr_d : '0;
      din_q      <= (run_d && !op_rd) ? (elem_cfg(elem_d).wr_inv ? ~bg_d : bg_d) : '0;
      bm_q       <= run_d ? '1 : '0;
`ifdef SRAM_BIST_CKBD_EN
      pass_q     <= pass_d;
`endif
    end
  end

  sram_bist_cmp #(
    .P_ADDR_WIDTH (P_ADDR_WIDTH),
    .P_DATA_WIDTH (P_DATA_WIDTH)
  ) u_cmp (
    .clk       (A_BIST_CLK),
    .rst_n     (A_BIST_RST_N),
    .clear     (start_run),
    .rd_issue  (op_rd),
    .rd_exp    (exp_d),
    .rd_addr   (addr_d),
    .dout      (bist.A_DOUT),
    .fail      (FAIL),
    .fail_addr (FAIL_ADDR),
    .fail_data (FAIL_DATA)
  );

  assign BUSY             = busy_q;
  assign DONE             = done_q;
  assign bist.A_BIST_EN   = busy_q;
  assign bist.A_BIST_MEN  = men_q;
  assign bist.A_BIST_WEN  = wen_q;
  assign bist.A_BIST_REN  = ren_q;
  assign bist.A_BIST_ADDR = addr_out_q;
  assign bist.A_BIST_DIN  = din_q;
  assign bist.A_BIST_BM   = bm_q;

endmodule

// File: tb/tb_sram_bist_march_ctrl.sv
// Directed bench for sram_bist_march_ctrl against a behavioural 256x8 SRAM with
// injectable stuck-at-1 read faults; honours SRAM_BIST_CKBD_EN for the pass count.
module tb_sram_bist_march_ctrl;

  localparam int N = 256;
`ifdef SRAM_BIST_CKBD_EN
  localparam int PASSES = 2;
`else
  localparam int PASSES = 1;
`endif
  localparam int TOTAL = 10 * N * PASSES;
  localparam int LIMIT = TOTAL + 64;

  logic       A_BIST_CLK = 1'b0;
  logic       A_BIST_RST_N = 1'b0;
  logic       START = 1'b0;
  logic       BUSY, DONE, FAIL;
  logic [7:0] FAIL_ADDR, FAIL_DATA;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [0:N-1];
  logic       f0_en = 1'b0, f1_en = 1'b0;
  logic [7:0] f0_addr = 8'h00, f1_addr = 8'h00;

  int         r_ops, r_seq_err, r_proto_err, r_start_err, r_done_cyc, r_fail_cyc;
  int         r_e3_first, r_e3_last;
  logic [7:0] r_pass2_din;

  always #5 A_BIST_CLK = ~A_BIST_CLK;

  sram_bist_march_ctrl_if #(.P_ADDR_WIDTH(8), .P_DATA_WIDTH(8)) bif ();

  sram_bist_march_ctrl #(.P_ADDR_WIDTH(8), .P_DATA_WIDTH(8)) dut (
    .A_BIST_CLK   (A_BIST_CLK),
    .A_BIST_RST_N (A_BIST_RST_N),
    .START        (START),
    .BUSY         (BUSY),
    .DONE         (DONE),
    .FAIL         (FAIL),
    .FAIL_ADDR    (FAIL_ADDR),
    .FAIL_DATA    (FAIL_DATA),
    .bist         (bif)
  );

  // Synchronous SRAM: one-cycle read latency, byte-mask writes, stuck-at-1 on bit 3 at fault addresses.
  always @(posedge A_BIST_CLK) begin
    if (bif.A_BIST_EN && bif.A_BIST_MEN) begin
      if (bif.A_BIST_WEN)
        mem[bif.A_BIST_ADDR] <= (mem[bif.A_BIST_ADDR] & ~bif.A_BIST_BM) | (bif.A_BIST_DIN & bif.A_BIST_BM);
      if (bif.A_BIST_REN)
        bif.A_DOUT <= mem[bif.A_BIST_ADDR]
                    | ((f0_en && bif.A_BIST_ADDR == f0_addr) ? 8'h08 : 8'h00)
                    | ((f1_en && bif.A_BIST_ADDR == f1_addr) ? 8'h08 : 8'h00);
    end
  end

  function automatic void model_op(input int i, output logic is_rd, output logic [7:0] addr,
                                   output logic [7:0] din);
    int p, r, j, e, k;
    logic [7:0] bg;
    p  = i / (10 * N);
    r  = i % (10 * N);
    bg = (p != 0) ? 8'h55 : 8'h00;
    if (r < N) begin
      is_rd = 1'b0; addr = 8'(r); din = bg;
    end else if (r >= 9 * N) begin
      is_rd = 1'b1; addr = 8'(r - 9 * N); din = 8'h00;
    end else begin
      j = r - N;
      e = j / (2 * N) + 1;
      k = j % (2 * N);
      addr  = (e <= 2) ? 8'(k / 2) : 8'(N - 1 - k / 2);
      is_rd = (k % 2 == 0);
      din   = is_rd ? 8'h00 : ((e == 1 || e == 3) ? ~bg : bg);
    end
  endfunction

  task automatic do_run(input int pulse_at);
    int c;
    logic exp_rd;
    logic [7:0] exp_addr, exp_din;
    bit finished;
    r_ops = 0; r_seq_err = 0; r_proto_err = 0; r_start_err = 0;
    r_done_cyc = -1; r_fail_cyc = -1; r_e3_first = -1; r_e3_last = -1; r_pass2_din = 8'hxx;
    finished = 0;
    @(negedge A_BIST_CLK);
    START = 1'b1;
    @(posedge A_BIST_CLK);
    #1 START = 1'b0;
    c = 0;
    while (!finished && c < LIMIT) begin
      @(negedge A_BIST_CLK);
      START = (pulse_at >= 0 && c == pulse_at);
      if (c == 0 && (!BUSY || DONE || FAIL)) r_start_err++;
      if (FAIL && r_fail_cyc < 0) r_fail_cyc = c;
      if (bif.A_BIST_EN !== BUSY || (DONE && BUSY)) r_proto_err++;
      if (bif.A_BIST_MEN) begin
        if (!(bif.A_BIST_WEN ^ bif.A_BIST_REN) || bif.A_BIST_BM !== 8'hFF || !BUSY) r_proto_err++;
        if (r_ops >= TOTAL || r_ops != c) r_seq_err++;
        else begin
          model_op(r_ops, exp_rd, exp_addr, exp_din);
          if (bif.A_BIST_REN !== exp_rd || bif.A_BIST_ADDR !== exp_addr || bif.A_BIST_DIN !== exp_din)
            r_seq_err++;
        end
        if (r_ops == 5 * N) r_e3_first = int'(bif.A_BIST_ADDR);
        if (r_ops == 7 * N - 1) r_e3_last = int'(bif.A_BIST_ADDR);
        if (r_ops == 10 * N) r_pass2_din = bif.A_BIST_DIN;
        r_ops++;
      end else if (bif.A_BIST_WEN || bif.A_BIST_REN || bif.A_BIST_ADDR != 0 || bif.A_BIST_DIN != 0 || bif.A_BIST_BM != 0) begin
        r_proto_err++;
      end
      if (DONE) begin
        r_done_cyc = c;
        finished = 1;
      end
      c++;
    end
    START = 1'b0;
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    #12;
    checks++; if ({BUSY, DONE, FAIL} !== 3'b000) begin errors++; $display("[TB] FAIL reset_status: got %b expected 000", {BUSY, DONE, FAIL}); end
    checks++; if ({FAIL_ADDR, FAIL_DATA} !== 16'h0) begin errors++; $display("[TB] FAIL reset_fail_info: got %h expected 0000", {FAIL_ADDR, FAIL_DATA}); end
    checks++; if ({bif.A_BIST_EN, bif.A_BIST_MEN, bif.A_BIST_WEN, bif.A_BIST_REN} !== 4'b0) begin errors++; $display("[TB] FAIL reset_ctrl: got %b expected 0000", {bif.A_BIST_EN, bif.A_BIST_MEN, bif.A_BIST_WEN, bif.A_BIST_REN}); end
    checks++; if ({bif.A_BIST_ADDR, bif.A_BIST_DIN, bif.A_BIST_BM} !== 24'h0) begin errors++; $display("[TB] FAIL reset_bus: got %h expected 000000", {bif.A_BIST_ADDR, bif.A_BIST_DIN, bif.A_BIST_BM}); end
    @(negedge A_BIST_CLK);
    A_BIST_RST_N = 1'b1;
    repeat (2) @(negedge A_BIST_CLK);
  endtask

  task automatic test_clean_run(input string tag, input int pulse_at);
    $display("[TB] test_clean_run %s", tag);
    f0_en = 1'b0; f1_en = 1'b0;
    do_run(pulse_at);
    checks++; if (r_ops !== TOTAL) begin errors++; $display("[TB] FAIL %s op_count: got %0d expected %0d", tag, r_ops, TOTAL); end
    checks++; if (r_seq_err !== 0) begin errors++; $display("[TB] FAIL %s op_sequence: got %0d bad ops expected 0", tag, r_seq_err); end
    checks++; if (r_done_cyc !== TOTAL + 1) begin errors++; $display("[TB] FAIL %s done_edge: got k+%0d expected k+%0d", tag, r_done_cyc, TOTAL + 1); end
    checks++; if (r_fail_cyc !== -1 || FAIL !== 1'b0) begin errors++; $display("[TB] FAIL %s clean_flag: got cycle %0d flag %b expected none", tag, r_fail_cyc, FAIL); end
    checks++; if (r_proto_err !== 0 || r_start_err !== 0) begin errors++; $display("[TB] FAIL %s protocol: got %0d/%0d expected 0/0", tag, r_proto_err, r_start_err); end
    checks++; if (r_e3_first !== 255 || r_e3_last !== 0) begin errors++; $display("[TB] FAIL %s e3_order: got %0d..%0d expected 255..0", tag, r_e3_first, r_e3_last); end
`ifdef SRAM_BIST_CKBD_EN
    checks++; if (r_pass2_din !== 8'h55) begin errors++; $display("[TB] FAIL %s pass2_din: got %h expected 55", tag, r_pass2_din); end
`endif
    @(negedge A_BIST_CLK);
    checks++; if (DONE !== 1'b1 || BUSY !== 1'b0) begin errors++; $display("[TB] FAIL %s done_sticky: got done %b busy %b expected 1 0", tag, DONE, BUSY); end
  endtask

  task automatic test_stuck_bit();
    $display("[TB] test_stuck_bit");
    f0_en = 1'b1; f0_addr = 8'h2A; f1_en = 1'b0;
    do_run(-1);
    checks++; if (FAIL !== 1'b1 || FAIL_ADDR !== 8'h2A || FAIL_DATA !== 8'h08) begin errors++; $display("[TB] FAIL stuck_capture: got %b/%h/%h expected 1/2a/08", FAIL, FAIL_ADDR, FAIL_DATA); end
    checks++; if (r_fail_cyc !== N + 2 * 8'h2A + 2) begin errors++; $display("[TB] FAIL stuck_fail_edge: got k+%0d expected k+%0d", r_fail_cyc, N + 2 * 8'h2A + 2); end
    checks++; if (r_ops !== TOTAL || r_done_cyc !== TOTAL + 1) begin errors++; $display("[TB] FAIL stuck_completes: got %0d ops done k+%0d expected %0d ops done k+%0d", r_ops, r_done_cyc, TOTAL, TOTAL + 1); end
    f0_en = 1'b0;
  endtask

  task automatic test_two_faults();
    $display("[TB] test_two_faults");
    f0_en = 1'b1; f0_addr = 8'h10; f1_en = 1'b1; f1_addr = 8'h80;
    do_run(-1);
    checks++; if (r_start_err !== 0) begin errors++; $display("[TB] FAIL restart_from_done: got %0d bad start samples expected 0", r_start_err); end
    checks++; if (FAIL !== 1'b1 || FAIL_ADDR !== 8'h10 || FAIL_DATA !== 8'h08) begin errors++; $display("[TB] FAIL first_fault_kept: got %b/%h/%h expected 1/10/08", FAIL, FAIL_ADDR, FAIL_DATA); end
    f0_en = 1'b0; f1_en = 1'b0;
  endtask

  task automatic test_reset_midrun();
    int c, n;
    $display("[TB] test_reset_midrun");
    f0_en = 1'b1; f0_addr = 8'h2A;
    @(negedge A_BIST_CLK);
    START = 1'b1;
    @(posedge A_BIST_CLK);
    #1 START = 1'b0;
    n = 0; c = 0;
    while (n < 1000 && c < 2000) begin
      @(negedge A_BIST_CLK);
      if (bif.A_BIST_MEN) n++;
      c++;
    end
    checks++; if (n !== 1000 || FAIL !== 1'b1) begin errors++; $display("[TB] FAIL midrun_reach: got %0d ops flag %b expected 1000 ops flag 1", n, FAIL); end
    A_BIST_RST_N = 1'b0;
    #1;
    checks++; if ({BUSY, DONE, FAIL, FAIL_ADDR, FAIL_DATA} !== 19'h0) begin errors++; $display("[TB] FAIL midrun_status_zero: got %h expected 0", {BUSY, DONE, FAIL, FAIL_ADDR, FAIL_DATA}); end
    checks++; if ({bif.A_BIST_EN, bif.A_BIST_MEN, bif.A_BIST_WEN, bif.A_BIST_REN, bif.A_BIST_ADDR, bif.A_BIST_DIN, bif.A_BIST_BM} !== 28'h0) begin errors++; $display("[TB] FAIL midrun_bus_zero: got %h expected 0", {bif.A_BIST_EN, bif.A_BIST_MEN, bif.A_BIST_WEN, bif.A_BIST_REN, bif.A_BIST_ADDR, bif.A_BIST_DIN, bif.A_BIST_BM}); end
    f0_en = 1'b0;
    @(negedge A_BIST_CLK);
    A_BIST_RST_N = 1'b1;
    repeat (2) @(negedge A_BIST_CLK);
    checks++; if (BUSY !== 1'b0 || DONE !== 1'b0) begin errors++; $display("[TB] FAIL midrun_idle: got busy %b done %b expected 0 0", BUSY, DONE); end
    test_clean_run("after_reset", -1);
  endtask

  initial begin
    test_reset();
    test_clean_run("first", -1);
    test_stuck_bit();
    test_two_faults();
    test_clean_run("start_in_run", 500);
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
